// File: rtl/connect4_pkg.sv
// Shared Connect4 types: board size defaults, cell and game-status encodings, move FSM states.
package connect4_pkg;

  localparam int unsigned ROWS_DEF = 6;
  localparam int unsigned COLS_DEF = 7;
  localparam int unsigned ROW_W    = 3;
  localparam int unsigned COL_W    = 3;
  localparam int unsigned CNT_W    = 6;

  typedef enum logic [1:0] {
    CELL_EMPTY = 2'b00,
    CELL_P0    = 2'b01,
    CELL_P1    = 2'b10
  } cell_t;

  typedef enum logic [1:0] {
    GS_PLAYING = 2'b00,
    GS_P0_WIN  = 2'b01,
    GS_P1_WIN  = 2'b10,
    GS_DRAW    = 2'b11
  } game_status_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_CHECK,
    ST_UPDATE,
    ST_OVER
  } state_t;

endpackage

// File: rtl/move_controller_if.sv
// Move handshake bus: player drop request, board-memory write port and win-checker handshake.
// master = move controller side, slave = player/memory/checker side.
interface move_controller_if;
  import connect4_pkg::*;

  logic             drop_valid;
  logic [COL_W-1:0] drop_col;
  logic             drop_ready;
  logic             mem_we;
  logic [ROW_W-1:0] mem_row;
  logic [COL_W-1:0] mem_col;
  logic [1:0]       mem_data;
  logic             mem_clr;
  logic             chk_start;
  logic             chk_done;
  logic             chk_win;

  modport master (
    input  drop_valid, drop_col, chk_done, chk_win,
    output drop_ready, mem_we, mem_row, mem_col, mem_data, mem_clr, chk_start
  );

  modport slave (
    output drop_valid, drop_col, chk_done, chk_win,
    input  drop_ready, mem_we, mem_row, mem_col, mem_data, mem_clr, chk_start
  );

endinterface

// File: rtl/column_height_tracker.sv
// Per-column fill heights: one 3-bit counter per column with increment, clear and a read port.
// The read port is combinational; an out-of-range column reads as height 0 and not full.
module column_height_tracker
  import connect4_pkg::*;
#(
  parameter int unsigned ROWS = ROWS_DEF,
  parameter int unsigned COLS = COLS_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr_i,
  input  logic             inc_i,
  input  logic [COL_W-1:0] inc_col_i,
  input  logic [COL_W-1:0] rd_col_i,
  output logic [ROW_W-1:0] rd_height_o,
  output logic             col_full_o
);

  logic [ROW_W-1:0] height_q [COLS];

  // Height counters: clear wins over increment
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < int'(COLS); c++) height_q[c] <= '0;
    end else begin
      for (int c = 0; c < int'(COLS); c++) begin
        if (clr_i) begin
          height_q[c] <= '0;
        end else if (inc_i && (inc_col_i == COL_W'(c))) begin
          height_q[c] <= height_q[c] + ROW_W'(1);
        end
      end
    end
  end

  // Read mux for the addressed column
  always_comb begin
    rd_height_o = '0;
    for (int c = 0; c < int'(COLS); c++) begin
      if (rd_col_i == COL_W'(c)) rd_height_o = height_q[c];
    end
  end

  assign col_full_o = (rd_height_o == ROW_W'(ROWS));

endmodule

// File: rtl/move_controller.sv
// Connect4 move sequencer: validates a column drop, writes the cell, runs the win check and
// updates turn, move count and game status.
// Optional: define MOVE_TIMEOUT_EN to forfeit a turn after TIMEOUT_CYCLES idle cycles.
module move_controller
  import connect4_pkg::*;
#(
  parameter int unsigned ROWS           = ROWS_DEF,
  parameter int unsigned COLS           = COLS_DEF,
  parameter int unsigned TIMEOUT_CYCLES = 1000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                new_game,
  move_controller_if.master   bus,
  output logic                invalid_move,
  output logic                player_turn,
  output logic                board_full,
  output logic [1:0]          game_status,
  output logic [CNT_W-1:0]    move_count,
  output logic                turn_timeout
);

  localparam int unsigned CELLS = ROWS * COLS;

  state_t           state_q;
  logic [ROW_W-1:0] row_q;
  logic [COL_W-1:0] col_q;
  logic [1:0]       data_q;
  logic             we_q;
  logic             clr_q;
  logic             start_q;
  logic             inv_q;
  logic             turn_q;
  logic             full_q;
  logic             win_q;
  logic [1:0]       status_q;
  logic [CNT_W-1:0] count_q;

  logic [ROW_W-1:0] height;
  logic             col_full;
  logic             bad_drop;

  column_height_tracker #(
    .ROWS (ROWS),
    .COLS (COLS)
  ) u_heights (
    .clk         (clk),
    .reset       (reset),
    .clr_i       (new_game),
    .inc_i       ((state_q == ST_WRITE) && !new_game),
    .inc_col_i   (col_q),
    .rd_col_i    (bus.drop_col),
    .rd_height_o (height),
    .col_full_o  (col_full)
  );

  assign bad_drop = (32'(bus.drop_col) >= COLS) || col_full;

`ifdef MOVE_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TO_W-1:0] to_cnt_q;
  logic            to_pulse_q;
  logic            to_expire;

  assign to_expire = (state_q == ST_IDLE) && (status_q == 2'(GS_PLAYING)) && !bus.drop_valid &&
                     (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

  // Idle-turn counter: runs only while waiting for a drop in a live game
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      to_cnt_q   <= '0;
      to_pulse_q <= 1'b0;
    end else begin
      to_pulse_q <= 1'b0;
      if (new_game || (state_q != ST_IDLE) || (status_q != 2'(GS_PLAYING)) || bus.drop_valid) begin
        to_cnt_q <= '0;
      end else if (to_expire) begin
        to_cnt_q   <= '0;
        to_pulse_q <= 1'b1;
      end else begin
        to_cnt_q <= to_cnt_q + TO_W'(1);
      end
    end
  end

  assign turn_timeout = to_pulse_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^32'(TIMEOUT_CYCLES);
  assign turn_timeout = 1'b0;
`endif

  // Move FSM with registered strobes; new_game overrides any state and any drop
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      row_q    <= '0;
      col_q    <= '0;
      data_q   <= 2'(CELL_EMPTY);
      we_q     <= 1'b0;
      clr_q    <= 1'b0;
      start_q  <= 1'b0;
      inv_q    <= 1'b0;
      turn_q   <= 1'b0;
      full_q   <= 1'b0;
      win_q    <= 1'b0;
      status_q <= 2'(GS_PLAYING);
      count_q  <= '0;
    end else begin
      we_q    <= 1'b0;
      clr_q   <= 1'b0;
      start_q <= 1'b0;
      inv_q   <= 1'b0;
      if (new_game) begin
        state_q  <= ST_IDLE;
        clr_q    <= 1'b1;
        turn_q   <= 1'b0;
        full_q   <= 1'b0;
        win_q    <= 1'b0;
        status_q <= 2'(GS_PLAYING);
        count_q  <= '0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (bus.drop_valid) begin
              if (bad_drop) begin
                inv_q <= 1'b1;
              end else begin
                row_q   <= height;
                col_q   <= bus.drop_col;
                data_q  <= turn_q ? 2'(CELL_P1) : 2'(CELL_P0);
                we_q    <= 1'b1;
                state_q <= ST_WRITE;
              end
            end
`ifdef MOVE_TIMEOUT_EN
            else if (to_expire) begin
              turn_q <= !turn_q;
            end
`endif
          end
          ST_WRITE: begin
            count_q <= count_q + CNT_W'(1);
            start_q <= 1'b1;
            state_q <= ST_CHECK;
          end
          ST_CHECK: begin
            if (bus.chk_done) begin
              win_q   <= bus.chk_win;
              state_q <= ST_UPDATE;
            end
          end
          ST_UPDATE: begin
            full_q <= (count_q == CNT_W'(CELLS));
            if (win_q) begin
              status_q <= turn_q ? 2'(GS_P1_WIN) : 2'(GS_P0_WIN);
              state_q  <= ST_OVER;
            end else if (count_q == CNT_W'(CELLS)) begin
              status_q <= 2'(GS_DRAW);
              state_q  <= ST_OVER;
            end else begin
              turn_q  <= !turn_q;
              state_q <= ST_IDLE;
            end
          end
          ST_OVER: begin
            state_q <= ST_OVER;
          end
          default: begin
            state_q <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign bus.drop_ready = (state_q == ST_IDLE);
  assign bus.mem_we     = we_q;
  assign bus.mem_row    = row_q;
  assign bus.mem_col    = col_q;
  assign bus.mem_data   = data_q;
  assign bus.mem_clr    = clr_q;
  assign bus.chk_start  = start_q;
  assign invalid_move   = inv_q;
  assign player_turn    = turn_q;
  assign board_full     = full_q;
  assign game_status    = status_q;
  assign move_count     = count_q;

endmodule

// File: tb/tb_move_controller.sv
// Testbench for move_controller: directed scenarios plus randomized play checked against a
// board-level model (column heights, turn, move count, status).
module tb_move_controller;

`ifdef MOVE_TIMEOUT_EN
  localparam int unsigned TO_CYC = 16;
`else
  localparam int unsigned TO_CYC = 1000;
`endif
  localparam int NR = 6;
  localparam int NC = 7;

  logic       clk = 1'b0;
  logic       reset;
  logic       new_game;
  logic       invalid_move;
  logic       player_turn;
  logic       board_full;
  logic [1:0] game_status;
  logic [5:0] move_count;
  logic       turn_timeout;

  move_controller_if bus ();

  move_controller #(
    .ROWS           (6),
    .COLS           (7),
    .TIMEOUT_CYCLES (TO_CYC)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .new_game     (new_game),
    .bus          (bus),
    .invalid_move (invalid_move),
    .player_turn  (player_turn),
    .board_full   (board_full),
    .game_status  (game_status),
    .move_count   (move_count),
    .turn_timeout (turn_timeout)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  // Reference model of the game
  int h [NC];
  int m_turn;
  int m_status;
  int m_count;
  int m_full;

  task automatic model_reset();
    for (int c = 0; c < NC; c++) h[c] = 0;
    m_turn = 0; m_status = 0; m_count = 0; m_full = 0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_status(input string tag);
    check({tag, "_turn"},   player_turn, m_turn);
    check({tag, "_status"}, game_status, m_status);
    check({tag, "_full"},   board_full, m_full);
    check({tag, "_count"},  move_count, m_count);
    check({tag, "_ready"},  bus.drop_ready, (m_status == 0) ? 1 : 0);
  endtask

  // One drop from the current player; chk_done follows chk_start after lat idle cycles
  task automatic do_move(input int col, input bit win, input int lat);
    bit valid;
    valid = (col < NC) && (h[col < NC ? col : 0] < NR);
    check("pre_ready", bus.drop_ready, 1);
    bus.drop_valid = 1'b1;
    bus.drop_col   = 3'(col);
    tick();
    bus.drop_valid = 1'b0;
    bus.drop_col   = 3'($urandom);
    if (!valid) begin
      check("inv_pulse", invalid_move, 1);
      check("inv_no_we", bus.mem_we, 0);
      tick();
      check("inv_clear", invalid_move, 0);
      check("inv_ready", bus.drop_ready, 1);
      check("inv_turn", player_turn, m_turn);
      check("inv_count", move_count, m_count);
      return;
    end
    check("wr_inv", invalid_move, 0);
    check("wr_we", bus.mem_we, 1);
    check("wr_row", bus.mem_row, h[col]);
    check("wr_col", bus.mem_col, col);
    check("wr_data", bus.mem_data, m_turn + 1);
    check("wr_nostart", bus.chk_start, 0);
    tick();
    check("chk_start", bus.chk_start, 1);
    check("chk_we_off", bus.mem_we, 0);
    for (int i = 0; i < lat; i++) begin
      tick();
      check("chk_start_once", bus.chk_start, 0);
      check("chk_wait_ready", bus.drop_ready, 0);
    end
    bus.chk_done = 1'b1;
    bus.chk_win  = win;
    tick();
    bus.chk_done = 1'b0;
    bus.chk_win  = 1'($urandom);
    check("upd_ready", bus.drop_ready, 0);
    tick();
    h[col]++;
    m_count++;
    if (win) m_status = (m_turn == 1) ? 2 : 1;
    else if (m_count == NR * NC) m_status = 3;
    else m_turn ^= 1;
    m_full = (m_count == NR * NC) ? 1 : 0;
    check_status("post");
  endtask

  task automatic do_new_game();
    new_game = 1'b1;
    tick();
    new_game = 1'b0;
    model_reset();
    check("ng_clr", bus.mem_clr, 1);
    check_status("ng");
    tick();
    check("ng_clr_once", bus.mem_clr, 0);
  endtask

  // A drop in OVER must be ignored
  task automatic over_drop();
    check("over_ready", bus.drop_ready, 0);
    bus.drop_valid = 1'b1;
    bus.drop_col   = 3'($urandom_range(0, 6));
    tick();
    bus.drop_valid = 1'b0;
    check("over_no_we", bus.mem_we, 0);
    check("over_no_inv", invalid_move, 0);
    tick();
    check_status("over");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    new_game = 1'b0;
    bus.drop_valid = 1'b0;
    bus.drop_col = '0;
    bus.chk_done = 1'b0;
    bus.chk_win = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", bus.drop_ready, 1);
    check("rst_we", bus.mem_we, 0);
    check("rst_clr", bus.mem_clr, 0);
    check("rst_start", bus.chk_start, 0);
    check("rst_inv", invalid_move, 0);
    check("rst_to", turn_timeout, 0);
    check_status("rst");
    reset = 1'b0;
    tick();

    // Stacking in column 3
    do_move(3, 1'b0, 0);
    do_move(3, 1'b0, 2);

    // Fill column 0, then overflow and out-of-range drops
    for (int i = 0; i < NR; i++) do_move(0, 1'b0, i % 3);
    do_move(0, 1'b0, 0);
    do_move(7, 1'b0, 0);

    // P0 wins; drops then ignored until new_game
    do_move(5, 1'b1, 1);
    check("win_p0", game_status, 1);
    over_drop();
    do_new_game();

    // new_game beats a simultaneous drop
    do_move(2, 1'b0, 0);
    bus.drop_valid = 1'b1;
    bus.drop_col   = 3'd2;
    new_game       = 1'b1;
    tick();
    bus.drop_valid = 1'b0;
    new_game       = 1'b0;
    model_reset();
    check("prio_no_we", bus.mem_we, 0);
    check("prio_clr", bus.mem_clr, 1);
    tick();
    check_status("prio");
    do_move(2, 1'b0, 0);

    // new_game during CHECK abandons the move; late chk_done ignored
    bus.drop_valid = 1'b1;
    bus.drop_col   = 3'd4;
    tick();
    bus.drop_valid = 1'b0;
    tick();
    new_game = 1'b1;
    tick();
    new_game = 1'b0;
    model_reset();
    bus.chk_done = 1'b1;
    bus.chk_win  = 1'b1;
    tick();
    bus.chk_done = 1'b0;
    bus.chk_win  = 1'b0;
    tick();
    check_status("abandon");
    do_move(4, 1'b0, 0);

    // Asynchronous reset in the middle of WRITE
    bus.drop_valid = 1'b1;
    bus.drop_col   = 3'd4;
    tick();
    bus.drop_valid = 1'b0;
    check("mid_we", bus.mem_we, 1);
    reset = 1'b1;
    #1;
    model_reset();
    check("arst_we", bus.mem_we, 0);
    check("arst_start", bus.chk_start, 0);
    check("arst_clr", bus.mem_clr, 0);
    check_status("arst");
    #2;
    reset = 1'b0;
    tick();
    check("arst_ready", bus.drop_ready, 1);
    do_move(4, 1'b0, 0);
    check("arst_row", h[4], 1);

    // Draw: 42 non-winning moves
    do_new_game();
    for (int k = 0; k < NR * NC; k++) do_move(k / NR, 1'b0, $urandom_range(0, 3));
    check("draw_status", game_status, 3);
    check("draw_full", board_full, 1);
    over_drop();

    // Win on the final cell reports the winner
    do_new_game();
    for (int k = 0; k < NR * NC; k++) do_move(k / NR, (k == NR * NC - 1), $urandom_range(0, 3));
    check("lastwin_status", game_status, 2);
    check("lastwin_full", board_full, 1);
    over_drop();

    // Idle turn handling
    do_new_game();
    new_game = 1'b1;
    tick();
    new_game = 1'b0;
    model_reset();
`ifdef MOVE_TIMEOUT_EN
    for (int r = 0; r < 2; r++) begin
      for (int i = 1; i < 16; i++) begin
        tick();
        check("to_quiet", turn_timeout, 0);
      end
      tick();
      m_turn ^= 1;
      check("to_pulse", turn_timeout, 1);
      check("to_turn", player_turn, m_turn);
    end
    tick();
    check("to_once", turn_timeout, 0);
    for (int i = 0; i < 10; i++) tick();
    check("to_turn_hold", player_turn, m_turn);
`else
    for (int i = 0; i < 40; i++) begin
      tick();
      check("to_tied", turn_timeout, 0);
    end
    check("to_turn_hold", player_turn, m_turn);
`endif
    do_move(6, 1'b0, 0);

    // Randomized play against the model
    for (int n = 0; n < 160; n++) begin
      do_move($urandom_range(0, 7), ($urandom_range(0, 39) == 0), $urandom_range(0, 3));
      if (m_status != 0) begin
        over_drop();
        do_new_game();
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
